seg_scan_mux: RTL and testbench
===============================

# seg_scan_mux

Parametrised time-multiplexed digit scanner for common-anode/common-cathode seven-segment displays. It generalises the fixed 4-digit rotating selector to N digits, adding a built-in prescaler, a per-digit enable mask, an anti-ghosting blanking window and tear-free frame-synchronous data loading. It sits between the counter/value logic and the 7-segment decoder: it outputs the current digit code on `CNT` and drives the digit strobes on `AN`.

## Interface
- `NUM_DIGITS`, 4: number of digits scanned, 2..16.
- `DIGIT_W`, 4: bits per digit code.
- `PRESCALE`, 50000: CLK cycles per digit slot, ≥ 4.
- `BLANK`, 2: cycles at the start of each slot with all strobes inactive; must be < `PRESCALE`.
- `AN_ACTIVE_LOW`, 1: 1 = strobe active level is 0.

Ports:
- `CLK` in 1: clock, rising edge.
- `RST` in 1: synchronous, active-high reset.
- `DIGITS_IN` in NUM_DIGITS*DIGIT_W: digit codes; digit k is at `[k*DIGIT_W +: DIGIT_W]`; digit 0 is least significant.
- `LOAD` in 1: one-cycle strobe that captures `DIGITS_IN`.
- `DIGIT_EN` in NUM_DIGITS: per-digit scan enable mask, sampled live.
- `CNT` out DIGIT_W: code of the currently selected digit, registered.
- `AN` out NUM_DIGITS: digit strobes, registered, one-hot at active level or all inactive.
- `SEL` out clog2(NUM_DIGITS): index of the current digit, registered.
- `FRAME_DONE` out 1: one-cycle pulse when the scan wraps.

## Operation
- Registers:
  - `PCNT`: prescaler, 0..PRESCALE-1.
  - `IDX`: current digit index.
  - `HOLD`, `SHADOW`: NUM_DIGITS*DIGIT_W each.
  - `PEND`: 1 bit.
- Tick: asserted when `PCNT == PRESCALE-1`. `PCNT` then returns to 0; otherwise it increments.
- Advance on tick: `IDX` becomes the first index with `DIGIT_EN` set, searching cyclically from `IDX+1` (the search includes `IDX` itself last).
  - If no bit is set, `IDX` holds and `AN` stays all inactive.
- Wrap: a tick where new `IDX` ≤ old `IDX` with at least one digit enabled. Wrap pulses `FRAME_DONE` in the cycle after the tick edge, for exactly one cycle.
  - A single enabled digit wraps on every tick.
- Loading:
  - `LOAD` writes `DIGITS_IN` into `HOLD` and sets `PEND`.
  - On a wrap with `PEND`=1, `SHADOW` ← `HOLD` and `PEND` clears.
  - If `LOAD` and wrap coincide, `SHADOW` ← `DIGITS_IN` directly and `PEND` clears.
  - The displayed data never changes mid-frame.
- `CNT` = `SHADOW` digit at `IDX`.
- `SEL` = `IDX`.
- `AN`: bit `IDX` is active iff `PCNT` ≥ `BLANK`, `DIGIT_EN[IDX]`=1 and the digit is not blanked (see Configuration). All other bits are inactive.
- Clearing `DIGIT_EN[IDX]` mid-slot deactivates `AN` on the next edge; `IDX` moves at the next tick.

## Timing
- Reset values:
  - `PCNT`=0, `IDX`=0, `HOLD`=`SHADOW`=0, `PEND`=0.
  - `CNT`=0, `SEL`=0, `FRAME_DONE`=0.
  - `AN` = all inactive (all 1s when `AN_ACTIVE_LOW`=1).
- `RST` mid-frame discards `HOLD`/`PEND` and takes effect on the next edge.
- The first tick occurs at cycle `PRESCALE`-1 after reset release.
- `CNT`, `SEL` and `IDX` update on the same edge.
- `AN` is inactive for `BLANK` cycles after each slot change, then active for `PRESCALE-BLANK` cycles.
- `LOAD` to visible data: the next wrap, at most `NUM_DIGITS*PRESCALE` cycles.
- Frame period = (number of enabled digits) × `PRESCALE` cycles.

## Configuration
- `SEG_SCAN_LZB_EN` defined: leading-zero blanking.
  - A digit k is blanked when it is non-zero-index, its `SHADOW` code is 0, and every higher enabled digit is also 0.
  - Digit 0 is never blanked.
  - A blanked slot still consumes its `PRESCALE` time, with `AN` inactive.
  - `CNT` still outputs the 0 code.
- Not defined: no blanking logic; every enabled digit is lit.

## Structure
- Package `seg_scan_pkg`:
  - `AN_OFF`/`AN_ON` level helpers parametrised by polarity.
  - A one-hot decode function.
  - A cyclic next-enabled-index function.
  - A `clog2` width helper.
- Sub-module `seg_prescaler`: holds `PCNT`, outputs `TICK` and `IN_BLANK`, with parameters `PRESCALE` and `BLANK`.
- Index search, load shadowing and blanking stay in the top module.

## Test plan
- Setup for all scenarios unless stated: `NUM_DIGITS`=4, `PRESCALE`=8, `BLANK`=2, active-low.
- Reset and basic scan:
  - Stimulus: after reset, `LOAD` 0x4321, `DIGIT_EN`=1111.
  - Required: `AN` reads 1111 for 2 cycles then 1110 in slot 0; `SEL` steps 0,1,2,3,0 every 8 cycles; after the first wrap `CNT` shows 1,2,3,4; `FRAME_DONE` pulses once per 32 cycles.
- Tear-free load:
  - Stimulus: `LOAD` 0x8765 while `SEL`=1.
  - Required: `CNT` keeps the old codes for slots 2 and 3; new codes appear from the slot-0 after the wrap.
- Mask skip:
  - Stimulus: `DIGIT_EN`=0101.
  - Required: `SEL` alternates 0,2,0,2; frame period is 16 cycles; with `DIGIT_EN`=0000, `AN` stays 1111 and `FRAME_DONE` stays 0.
- Coincident `LOAD` and wrap:
  - Stimulus: `LOAD` 0x1111 on the wrap-tick cycle.
  - Required: the slot-0 `CNT` after that edge is 1.
- Leading-zero blanking with `SEG_SCAN_LZB_EN`:
  - Stimulus: data 0x0050.
  - Required: slots 3 and 2 keep `AN`=1111; slots 1 and 0 light. With data 0x0000, only digit 0 lights.
- Mid-frame reset:
  - Stimulus: assert `RST` at `SEL`=2 with `PEND`=1.
  - Required: all outputs return to their reset values; the pending data is never displayed.

Source files
------------

// File: rtl/seg_scan_pkg.sv
// rtl/seg_scan_pkg.sv - strobe level helpers, one-hot decode and cyclic digit search for seg_scan_mux
package seg_scan_pkg;

    localparam int MAX_DIGITS = 16;

    function automatic logic an_off(input bit active_low);
        return active_low;
    endfunction

    function automatic logic an_on(input bit active_low);
        return !active_low;
    endfunction

    function automatic logic [MAX_DIGITS-1:0] onehot(input logic [3:0] idx);
        logic [MAX_DIGITS-1:0] v;
        v = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // Walks downwards so the last hit kept is the nearest enabled index after idx;
    // idx itself is considered last, and returned unchanged when nothing is enabled.
    function automatic logic [3:0] next_enabled(input logic [MAX_DIGITS-1:0] en,
                                                input logic [3:0] idx,
                                                input int n);
        logic [3:0] r;
        int cand;
        r = idx;
        for (int step = MAX_DIGITS; step >= 1; step--) begin
            if (step <= n) begin
                cand = (int'(idx) + step) % n;
                if (en[4'(cand)]) r = 4'(cand);
            end
        end
        return r;
    endfunction

    function automatic int sel_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/seg_scan_mux_if.sv
// rtl/seg_scan_mux_if.sv - data/strobe bundle between value logic and the digit scanner
interface seg_scan_mux_if
    import seg_scan_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int DIGIT_W    = 4
);
    localparam int SEL_W = sel_width(NUM_DIGITS);

    logic [NUM_DIGITS*DIGIT_W-1:0] DIGITS_IN;
    logic                          LOAD;
    logic [NUM_DIGITS-1:0]         DIGIT_EN;
    logic [DIGIT_W-1:0]            CNT;
    logic [NUM_DIGITS-1:0]         AN;
    logic [SEL_W-1:0]              SEL;
    logic                          FRAME_DONE;

    modport master (
        output DIGITS_IN, LOAD, DIGIT_EN,
        input  CNT, AN, SEL, FRAME_DONE
    );

    modport slave (
        input  DIGITS_IN, LOAD, DIGIT_EN,
        output CNT, AN, SEL, FRAME_DONE
    );

endinterface

// File: rtl/seg_prescaler.sv
// rtl/seg_prescaler.sv - digit slot timer producing the slot tick and the blanking window
module seg_prescaler #(
    parameter int PRESCALE = 50000,
    parameter int BLANK    = 2
) (
    input  logic CLK,
    input  logic RST,
    output logic TICK,
    output logic IN_BLANK
);
    localparam int PW = $clog2(PRESCALE);

    logic [PW-1:0] pcnt;
    logic [PW-1:0] pcnt_n;

    // IN_BLANK describes the upcoming cycle so the registered strobes line up with PCNT.
    always_comb begin
        TICK     = (pcnt == PW'(PRESCALE - 1));
        pcnt_n   = TICK ? '0 : pcnt + PW'(1);
        IN_BLANK = (pcnt_n < PW'(BLANK));
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            pcnt <= '0;
        end else begin
            pcnt <= pcnt_n;
        end
    end

endmodule

// File: rtl/seg_scan_mux.sv
// rtl/seg_scan_mux.sv - N-digit seven-segment scanner; define SEG_SCAN_LZB_EN for leading-zero blanking
module seg_scan_mux
    import seg_scan_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int DIGIT_W       = 4,
    parameter int PRESCALE      = 50000,
    parameter int BLANK         = 2,
    parameter bit AN_ACTIVE_LOW = 1'b1
) (
    input  logic          CLK,
    input  logic          RST,
    seg_scan_mux_if.slave bus
);
    localparam int SEL_W  = sel_width(NUM_DIGITS);
    localparam int DATA_W = NUM_DIGITS * DIGIT_W;

    logic                  tick;
    logic                  in_blank;
    logic [SEL_W-1:0]      idx;
    logic [SEL_W-1:0]      idx_n;
    logic [DATA_W-1:0]     hold;
    logic [DATA_W-1:0]     shadow;
    logic [DATA_W-1:0]     shadow_n;
    logic                  pend;
    logic                  any_en;
    logic                  wrap;
    logic                  lit;
    logic [MAX_DIGITS-1:0] en16;
    logic [NUM_DIGITS-1:0] lz;
    logic [NUM_DIGITS-1:0] oh;
    logic [NUM_DIGITS-1:0] an_n;
`ifdef SEG_SCAN_LZB_EN
    logic                  zero_above;
    logic                  code_zero;
`endif

    seg_prescaler #(
        .PRESCALE (PRESCALE),
        .BLANK    (BLANK)
    ) u_prescaler (
        .CLK      (CLK),
        .RST      (RST),
        .TICK     (tick),
        .IN_BLANK (in_blank)
    );

    always_comb begin
        en16 = '0;
        en16[NUM_DIGITS-1:0] = bus.DIGIT_EN;
        any_en = |bus.DIGIT_EN;
        idx_n  = tick ? SEL_W'(next_enabled(en16, 4'(idx), NUM_DIGITS)) : idx;
        wrap   = tick && any_en && (idx_n <= idx);

        // New data only ever lands on a frame boundary, so a frame is never torn.
        shadow_n = shadow;
        if (wrap && bus.LOAD) begin
            shadow_n = bus.DIGITS_IN;
        end else if (wrap && pend) begin
            shadow_n = hold;
        end

        lz = '0;
`ifdef SEG_SCAN_LZB_EN
        zero_above = 1'b1;
        code_zero  = 1'b0;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            code_zero = (shadow_n[k*DIGIT_W +: DIGIT_W] == '0);
            lz[k]     = code_zero && zero_above;
            if (bus.DIGIT_EN[k] && !code_zero) zero_above = 1'b0;
        end
`endif

        lit = !in_blank && bus.DIGIT_EN[idx_n] && !lz[idx_n];
        oh  = NUM_DIGITS'(onehot(4'(idx_n)));
        for (int i = 0; i < NUM_DIGITS; i++) begin
            an_n[i] = (lit && oh[i]) ? an_on(AN_ACTIVE_LOW) : an_off(AN_ACTIVE_LOW);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            idx            <= '0;
            hold           <= '0;
            shadow         <= '0;
            pend           <= 1'b0;
            bus.CNT        <= '0;
            bus.SEL        <= '0;
            bus.AN         <= {NUM_DIGITS{an_off(AN_ACTIVE_LOW)}};
            bus.FRAME_DONE <= 1'b0;
        end else begin
            idx    <= idx_n;
            shadow <= shadow_n;
            if (bus.LOAD) hold <= bus.DIGITS_IN;
            if (wrap) begin
                pend <= 1'b0;
            end else if (bus.LOAD) begin
                pend <= 1'b1;
            end
            bus.CNT        <= shadow_n[idx_n*DIGIT_W +: DIGIT_W];
            bus.SEL        <= idx_n;
            bus.AN         <= an_n;
            bus.FRAME_DONE <= wrap;
        end
    end

endmodule

// File: tb/tb_seg_scan_mux.sv
// tb/tb_seg_scan_mux.sv - slot scoreboard bench for seg_scan_mux (4 digits, PRESCALE 8, BLANK 2, active-low)
module tb_seg_scan_mux;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    seg_scan_mux_if #(.NUM_DIGITS(4), .DIGIT_W(4)) bus ();

    seg_scan_mux #(
        .NUM_DIGITS    (4),
        .DIGIT_W       (4),
        .PRESCALE      (8),
        .BLANK         (2),
        .AN_ACTIVE_LOW (1'b1)
    ) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    typedef struct {
        logic [1:0] sel;
        logic [3:0] cnt;
        logic [3:0] an;
        logic       fd;
    } slot_t;

    slot_t sb[$];
    int total = 0;
    int bad   = 0;
    int ph    = 0;

    // Phase within the current 8-cycle digit slot, restarted by reset.
    always @(posedge clk) begin
        if (rst) ph <= 0;
        else     ph <= (ph == 7) ? 0 : ph + 1;
    end

    function automatic logic [3:0] lit(input int k);
        logic [3:0] v;
        v = 4'b0001;
        v = v << k;
        return ~v;
    endfunction

    task automatic push(input int sel, input int cnt, input logic [3:0] an, input bit fd);
        slot_t e;
        e.sel = 2'(sel);
        e.cnt = 4'(cnt);
        e.an  = an;
        e.fd  = fd;
        sb.push_back(e);
    endtask

    task automatic wait_ph(input int p);
        int n = 0;
        while (ph != p && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (ph != p) begin
            total++; bad++;
            $display("FAIL wait_ph: phase=%0d required=%0d", ph, p);
        end
    endtask

    task automatic wait_sel(input logic [1:0] s);
        int n = 0;
        while (bus.SEL !== s && n < 64) begin
            @(negedge clk);
            n++;
        end
        if (bus.SEL !== s) begin
            total++; bad++;
            $display("FAIL wait_sel: sel=%0d required=%0d", bus.SEL, s);
        end
    endtask

    task automatic wait_fd();
        int n = 0;
        while (bus.FRAME_DONE !== 1'b1 && n < 64) begin
            @(negedge clk);
            n++;
        end
        if (bus.FRAME_DONE !== 1'b1) begin
            total++; bad++;
            $display("FAIL wait_fd: frame_done=%b required=1", bus.FRAME_DONE);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        total++; if (bus.SEL !== 2'd0) begin bad++; $display("FAIL reset_sel: sel=%0d required=0", bus.SEL); end
        total++; if (bus.CNT !== 4'h0) begin bad++; $display("FAIL reset_cnt: cnt=%h required=0", bus.CNT); end
        total++; if (bus.AN !== 4'hF) begin bad++; $display("FAIL reset_an: an=%b required=1111", bus.AN); end
        total++; if (bus.FRAME_DONE !== 1'b0) begin bad++; $display("FAIL reset_fd: fd=%b required=0", bus.FRAME_DONE); end
        @(negedge clk);
        total++; if (bus.AN !== 4'hF) begin bad++; $display("FAIL blank_ph1: an=%b required=1111", bus.AN); end
        @(negedge clk);
        total++; if (bus.AN !== 4'hE) begin bad++; $display("FAIL lit_ph2: an=%b required=1110", bus.AN); end
    endtask

    task automatic test_basic_scan();
        slot_t e;
        bus.DIGITS_IN = 16'h4321;
        bus.LOAD = 1'b1;
        @(negedge clk);
        bus.LOAD = 1'b0;
        push(1, 0, lit(1), 0); push(2, 0, lit(2), 0); push(3, 0, lit(3), 0);
        push(0, 1, lit(0), 1); push(1, 2, lit(1), 0); push(2, 3, lit(2), 0);
        push(3, 4, lit(3), 0); push(0, 1, lit(0), 1);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            wait_ph(0);
            total++;
            if (bus.SEL !== e.sel || bus.CNT !== e.cnt || bus.FRAME_DONE !== e.fd) begin
                bad++;
                $display("FAIL basic_slot: sel=%0d cnt=%h fd=%b required sel=%0d cnt=%h fd=%b",
                         bus.SEL, bus.CNT, bus.FRAME_DONE, e.sel, e.cnt, e.fd);
            end
            @(negedge clk); @(negedge clk);
            total++;
            if (bus.AN !== e.an || bus.FRAME_DONE !== 1'b0) begin
                bad++;
                $display("FAIL basic_an: an=%b fd=%b required an=%b fd=0", bus.AN, bus.FRAME_DONE, e.an);
            end
        end
    endtask

    task automatic test_tear_free();
        slot_t e;
        wait_ph(0);
        total++; if (bus.SEL !== 2'd1) begin bad++; $display("FAIL tear_sel: sel=%0d required=1", bus.SEL); end
        wait_ph(3);
        bus.DIGITS_IN = 16'h8765;
        bus.LOAD = 1'b1;
        @(negedge clk);
        bus.LOAD = 1'b0;
        push(2, 3, lit(2), 0); push(3, 4, lit(3), 0); push(0, 5, lit(0), 1);
        push(1, 6, lit(1), 0); push(2, 7, lit(2), 0); push(3, 8, lit(3), 0);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            wait_ph(0);
            total++;
            if (bus.SEL !== e.sel || bus.CNT !== e.cnt || bus.FRAME_DONE !== e.fd) begin
                bad++;
                $display("FAIL tear_slot: sel=%0d cnt=%h fd=%b required sel=%0d cnt=%h fd=%b",
                         bus.SEL, bus.CNT, bus.FRAME_DONE, e.sel, e.cnt, e.fd);
            end
            @(negedge clk); @(negedge clk);
            total++;
            if (bus.AN !== e.an) begin bad++; $display("FAIL tear_an: an=%b required=%b", bus.AN, e.an); end
        end
    endtask

    task automatic test_coincident();
        slot_t e;
        wait_ph(7);
        bus.DIGITS_IN = 16'h1111;
        bus.LOAD = 1'b1;
        @(negedge clk);
        bus.LOAD = 1'b0;
        push(0, 1, lit(0), 1); push(1, 1, lit(1), 0);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            wait_ph(0);
            total++;
            if (bus.SEL !== e.sel || bus.CNT !== e.cnt || bus.FRAME_DONE !== e.fd) begin
                bad++;
                $display("FAIL coincide_slot: sel=%0d cnt=%h fd=%b required sel=%0d cnt=%h fd=%b",
                         bus.SEL, bus.CNT, bus.FRAME_DONE, e.sel, e.cnt, e.fd);
            end
            @(negedge clk); @(negedge clk);
            total++;
            if (bus.AN !== e.an) begin bad++; $display("FAIL coincide_an: an=%b required=%b", bus.AN, e.an); end
        end
    endtask

    task automatic test_mask_skip();
        slot_t e;
        bus.DIGIT_EN = 4'b0101;
        @(negedge clk);
        total++; if (bus.AN !== 4'hF) begin bad++; $display("FAIL mask_midslot_an: an=%b required=1111", bus.AN); end
        total++; if (bus.SEL !== 2'd1) begin bad++; $display("FAIL mask_midslot_sel: sel=%0d required=1", bus.SEL); end
        push(2, 1, lit(2), 0); push(0, 1, lit(0), 1); push(2, 1, lit(2), 0); push(0, 1, lit(0), 1);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            wait_ph(0);
            total++;
            if (bus.SEL !== e.sel || bus.CNT !== e.cnt || bus.FRAME_DONE !== e.fd) begin
                bad++;
                $display("FAIL mask_slot: sel=%0d cnt=%h fd=%b required sel=%0d cnt=%h fd=%b",
                         bus.SEL, bus.CNT, bus.FRAME_DONE, e.sel, e.cnt, e.fd);
            end
            @(negedge clk); @(negedge clk);
            total++;
            if (bus.AN !== e.an) begin bad++; $display("FAIL mask_an: an=%b required=%b", bus.AN, e.an); end
        end
        bus.DIGIT_EN = 4'b0000;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            total++;
            if (bus.AN !== 4'hF || bus.FRAME_DONE !== 1'b0 || bus.SEL !== 2'd0) begin
                bad++;
                $display("FAIL mask_none: an=%b fd=%b sel=%0d required an=1111 fd=0 sel=0",
                         bus.AN, bus.FRAME_DONE, bus.SEL);
            end
        end
        bus.DIGIT_EN = 4'hF;
    endtask

    task automatic test_lzb();
        slot_t e;
        logic lzb;
`ifdef SEG_SCAN_LZB_EN
        lzb = 1'b1;
`else
        lzb = 1'b0;
`endif
        bus.DIGITS_IN = 16'h0050;
        bus.LOAD = 1'b1;
        @(negedge clk);
        bus.LOAD = 1'b0;
        wait_fd();
        push(0, 0, lit(0), 1); push(1, 5, lit(1), 0);
        push(2, 0, lzb ? 4'hF : lit(2), 0); push(3, 0, lzb ? 4'hF : lit(3), 0);
        push(0, 0, lit(0), 1);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            wait_ph(0);
            total++;
            if (bus.SEL !== e.sel || bus.CNT !== e.cnt || bus.FRAME_DONE !== e.fd) begin
                bad++;
                $display("FAIL lzb50_slot: sel=%0d cnt=%h fd=%b required sel=%0d cnt=%h fd=%b",
                         bus.SEL, bus.CNT, bus.FRAME_DONE, e.sel, e.cnt, e.fd);
            end
            @(negedge clk); @(negedge clk);
            total++;
            if (bus.AN !== e.an) begin bad++; $display("FAIL lzb50_an: an=%b required=%b", bus.AN, e.an); end
        end
        bus.DIGITS_IN = 16'h0000;
        bus.LOAD = 1'b1;
        @(negedge clk);
        bus.LOAD = 1'b0;
        wait_fd();
        push(0, 0, lit(0), 1); push(1, 0, lzb ? 4'hF : lit(1), 0);
        push(2, 0, lzb ? 4'hF : lit(2), 0); push(3, 0, lzb ? 4'hF : lit(3), 0);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            wait_ph(0);
            total++;
            if (bus.SEL !== e.sel || bus.CNT !== e.cnt || bus.FRAME_DONE !== e.fd) begin
                bad++;
                $display("FAIL lzb0_slot: sel=%0d cnt=%h fd=%b required sel=%0d cnt=%h fd=%b",
                         bus.SEL, bus.CNT, bus.FRAME_DONE, e.sel, e.cnt, e.fd);
            end
            @(negedge clk); @(negedge clk);
            total++;
            if (bus.AN !== e.an) begin bad++; $display("FAIL lzb0_an: an=%b required=%b", bus.AN, e.an); end
        end
    endtask

    task automatic test_mid_reset();
        slot_t e;
        wait_sel(2'd1);
        bus.DIGITS_IN = 16'h9999;
        bus.LOAD = 1'b1;
        @(negedge clk);
        bus.LOAD = 1'b0;
        wait_sel(2'd2);
        rst = 1'b1;
        @(negedge clk);
        total++;
        if (bus.SEL !== 2'd0 || bus.CNT !== 4'h0 || bus.AN !== 4'hF || bus.FRAME_DONE !== 1'b0) begin
            bad++;
            $display("FAIL midreset_outputs: sel=%0d cnt=%h an=%b fd=%b required sel=0 cnt=0 an=1111 fd=0",
                     bus.SEL, bus.CNT, bus.AN, bus.FRAME_DONE);
        end
        rst = 1'b0;
        push(0, 0, lit(0), 0); push(1, 0, lit(1), 0); push(2, 0, lit(2), 0);
        push(3, 0, lit(3), 0); push(0, 0, lit(0), 1); push(1, 0, lit(1), 0);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            wait_ph(0);
            total++;
            if (bus.SEL !== e.sel || bus.CNT !== e.cnt || bus.FRAME_DONE !== e.fd) begin
                bad++;
                $display("FAIL midreset_slot: sel=%0d cnt=%h fd=%b required sel=%0d cnt=%h fd=%b",
                         bus.SEL, bus.CNT, bus.FRAME_DONE, e.sel, e.cnt, e.fd);
            end
            @(negedge clk); @(negedge clk);
            total++;
            if (bus.AN !== e.an) begin bad++; $display("FAIL midreset_an: an=%b required=%b", bus.AN, e.an); end
        end
    endtask

    initial begin
        rst           = 1'b1;
        bus.LOAD      = 1'b0;
        bus.DIGITS_IN = '0;
        bus.DIGIT_EN  = 4'hF;
        repeat (3) @(negedge clk);
        test_reset();
        test_basic_scan();
        test_tear_free();
        test_coincident();
        test_mask_skip();
        test_lzb();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time exceeded, required completion");
        $fatal(1, "watchdog");
    end

endmodule
